// File: rtl/sw_debounce_sync_if.sv
// Switch-side bundle for sw_debounce_sync: raw switches in, debounced levels, edge pulses
// and the latch-clock edge count out.
interface sw_debounce_sync_if;
    logic [1:0] SW;
    logic [1:0] DB;
    logic [1:0] RISE;
    logic [1:0] FALL;
    logic [7:0] EDGE_CNT;

    modport master (
        output SW,
        input  DB,
        input  RISE,
        input  FALL,
        input  EDGE_CNT
    );

    modport slave (
        input  SW,
        output DB,
        output RISE,
        output FALL,
        output EDGE_CNT
    );
endinterface

// File: rtl/sw_debounce_sync.sv
// Two-channel slide-switch conditioner: 2-flop synchronizer, per-channel stability-window
// debouncer with registered rise/fall pulses, and a wrapping count of channel-1 rises.
module sw_debounce_sync #(
    parameter int unsigned CNT_MAX = 500000
) (
    input logic               CLOCK_50,
    input logic               Resetn,
    sw_debounce_sync_if.slave bus
);

    localparam int unsigned     CntW    = $clog2(CNT_MAX);
    localparam logic [CntW-1:0] CntLast = CntW'(CNT_MAX - 1);

    logic [1:0] meta_q;
    logic [1:0] sync_q;
    logic [1:0] db_v;
    logic [1:0] rise_v;
    logic [1:0] fall_v;
    logic [7:0] edge_cnt_q;

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= bus.SW;
            sync_q <= meta_q;
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_ch
        logic [CntW-1:0] cnt_q;
        logic [CntW-1:0] cnt_d;
        logic            db_q;
        logic            db_d;
        logic            rise_q;
        logic            rise_d;
        logic            fall_q;
        logic            fall_d;

        // Any cycle where the synchronized level agrees with DB restarts the window.
        always_comb begin
            cnt_d  = cnt_q;
            db_d   = db_q;
            rise_d = 1'b0;
            fall_d = 1'b0;
            if (sync_q[i] == db_q) begin
                cnt_d = '0;
            end else if (cnt_q == CntLast) begin
                cnt_d  = '0;
                db_d   = sync_q[i];
                rise_d = sync_q[i];
                fall_d = ~sync_q[i];
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end

        always_ff @(posedge CLOCK_50 or negedge Resetn) begin
            if (!Resetn) begin
                cnt_q  <= '0;
                db_q   <= 1'b0;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                db_q   <= db_d;
                rise_q <= rise_d;
                fall_q <= fall_d;
            end
        end

        assign db_v[i]   = db_q;
        assign rise_v[i] = rise_q;
        assign fall_v[i] = fall_q;

        no_dual_pulse: assert property (
            @(posedge CLOCK_50) disable iff (!Resetn) !(rise_q && fall_q)
        );
    end

    // Counts the cycle after each latch-clock rise; wraps silently at 255.
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            edge_cnt_q <= '0;
        end else if (rise_v[1]) begin
            edge_cnt_q <= edge_cnt_q + 8'd1;
        end
    end

    assign bus.DB       = db_v;
    assign bus.RISE     = rise_v;
    assign bus.FALL     = fall_v;
    assign bus.EDGE_CNT = edge_cnt_q;

endmodule

// File: tb/tb_sw_debounce_sync.sv
// Directed bench for sw_debounce_sync with CNT_MAX = 4: settle latency, bounce rejection,
// edge-count wrap, mid-window reset and simultaneous channel transitions.
module tb_sw_debounce_sync;

    localparam int unsigned CntMax = 4;

    logic clk = 1'b0;
    logic resetn;
    int   n_cmp = 0;
    int   n_err = 0;

    sw_debounce_sync_if bus ();

    sw_debounce_sync #(
        .CNT_MAX(CntMax)
    ) dut (
        .CLOCK_50(clk),
        .Resetn  (resetn),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Packed observation: {DB, RISE, FALL, EDGE_CNT}
    logic [13:0] obs;
    assign obs = {bus.DB, bus.RISE, bus.FALL, bus.EDGE_CNT};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b1;
        bus.SW = 2'b00;
        #1;
        resetn = 1'b0;
        #2;
        n_cmp++;
        if (obs !== 14'd0) begin
            n_err++;
            $display("FAIL reset_async: got %h want %h", obs, 14'd0);
        end
        repeat (3) tick();
        resetn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if (obs !== 14'd0) begin
                n_err++;
                $display("FAIL reset_idle cyc%0d: got %h want %h", i, obs, 14'd0);
            end
        end
    endtask

    task automatic test_rise0();
        logic [13:0] exp;
        bus.SW = 2'b01;
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (e < 6)       exp = 14'd0;
            else if (e == 6) exp = {2'b01, 2'b01, 2'b00, 8'd0};
            else             exp = {2'b01, 2'b00, 2'b00, 8'd0};
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL rise0 edge%0d: got %h want %h", e, obs, exp);
            end
        end
    endtask

    task automatic test_bounce1();
        logic [13:0] exp;
        bus.SW = 2'b11;
        repeat (2) begin
            tick();
            exp = {2'b01, 2'b00, 2'b00, 8'd0};
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL bounce_hi: got %h want %h", obs, exp);
            end
        end
        bus.SW = 2'b01;
        repeat (2) begin
            tick();
            exp = {2'b01, 2'b00, 2'b00, 8'd0};
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL bounce_lo: got %h want %h", obs, exp);
            end
        end
        bus.SW = 2'b11;
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (e < 6)       exp = {2'b01, 2'b00, 2'b00, 8'd0};
            else if (e == 6) exp = {2'b11, 2'b10, 2'b00, 8'd0};
            else             exp = {2'b11, 2'b00, 2'b00, 8'd1};
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL bounce_settle edge%0d: got %h want %h", e, obs, exp);
            end
        end
    endtask

    task automatic test_edge_wrap();
        logic [7:0]  exp_cnt;
        logic [13:0] exp;
        exp_cnt = 8'd1;
        for (int n = 1; n <= 255; n++) begin
            bus.SW = 2'b01;
            repeat (6) tick();
            exp = {2'b01, 2'b00, 2'b10, exp_cnt};
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL wrap_release n%0d: got %h want %h", n, obs, exp);
            end
            bus.SW = 2'b11;
            repeat (6) tick();
            exp = {2'b11, 2'b10, 2'b00, exp_cnt};
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL wrap_press n%0d: got %h want %h", n, obs, exp);
            end
            tick();
            exp_cnt = exp_cnt + 8'd1;
            exp = {2'b11, 2'b00, 2'b00, exp_cnt};
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL wrap_count n%0d: got %h want %h", n, obs, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [13:0] exp;
        bus.SW = 2'b10;
        repeat (6) tick();
        exp = {2'b10, 2'b00, 2'b01, 8'd0};
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL rmid_fall0: got %h want %h", obs, exp);
        end
        bus.SW = 2'b00;
        repeat (6) tick();
        bus.SW = 2'b10;
        repeat (7) tick();
        exp = {2'b10, 2'b00, 2'b00, 8'd1};
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL rmid_prep: got %h want %h", obs, exp);
        end
        // ch0 counter reaches 2 after the fourth edge
        bus.SW = 2'b11;
        repeat (4) tick();
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL rmid_window: got %h want %h", obs, exp);
        end
        resetn = 1'b0;
        #1;
        n_cmp++;
        if (obs !== 14'd0) begin
            n_err++;
            $display("FAIL rmid_async: got %h want %h", obs, 14'd0);
        end
        repeat (2) tick();
        resetn = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (e < 6)       exp = 14'd0;
            else if (e == 6) exp = {2'b11, 2'b11, 2'b00, 8'd0};
            else             exp = {2'b11, 2'b00, 2'b00, 8'd1};
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL rmid_restart edge%0d: got %h want %h", e, obs, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [13:0] exp;
        bus.SW = 2'b00;
        repeat (6) tick();
        exp = {2'b00, 2'b00, 2'b11, 8'd1};
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL simul_fall: got %h want %h", obs, exp);
        end
        bus.SW = 2'b11;
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (e < 6)       exp = {2'b00, 2'b00, 2'b00, 8'd1};
            else if (e == 6) exp = {2'b11, 2'b11, 2'b00, 8'd1};
            else             exp = {2'b11, 2'b00, 2'b00, 8'd2};
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL simul_rise edge%0d: got %h want %h", e, obs, exp);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_rise0();
        test_bounce1();
        test_edge_wrap();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sw_debounce_sync.md
SW_DEBOUNCE_SYNC -- requirements
Module: sw_debounce_sync

Interface
REQ-001 Parameter CNT_MAX, default 500000, sets the consecutive-cycle stability window per channel (10 ms at 50 MHz); legal range 2..2^20.
REQ-002 CLOCK_50  input  1  sole clock; every flop SHALL be rising-edge triggered on it.
REQ-003 Resetn  input  1  asynchronous, active-low reset.
REQ-004 SW  input  2  raw, bouncing, asynchronous slide switches: SW[0] is the data channel, SW[1] is the latch-clock channel.
REQ-005 DB  output  2  debounced, synchronized level per channel; feeds the master-slave latch stage as D (DB[0]) and Clk (DB[1]).
REQ-006 RISE  output  2  one-cycle pulse per channel when DB goes 0->1.
REQ-007 FALL  output  2  one-cycle pulse per channel when DB goes 1->0.
REQ-008 EDGE_CNT  output  8  count of RISE[1] pulses since reset.

Function
REQ-009 Each channel SHALL pass through a 2-flop synchronizer; the second flop output is "sync".
REQ-010 Each channel SHALL have an independent stability counter, width ceil(log2(CNT_MAX)), saturation-free.
REQ-011 Cycle with sync == DB: counter SHALL clear to 0.
REQ-012 Cycle with sync != DB and counter < CNT_MAX-1: counter SHALL increment by 1.
REQ-013 Cycle with sync != DB and counter == CNT_MAX-1: DB SHALL take sync at that edge, counter SHALL clear, and the matching RISE or FALL SHALL assert for exactly that one cycle (the cycle DB changes).
REQ-014 A raw change held steady SHALL appear on DB exactly 2 + CNT_MAX clock edges after it is first sampled.
REQ-015 Any bounce back to sync == DB before the window completes SHALL restart the count from 0; DB and pulses SHALL NOT change.
REQ-016 RISE and FALL of one channel SHALL never assert in the same cycle; between two pulses of one channel at least CNT_MAX cycles SHALL elapse.
REQ-017 The two channels SHALL be fully independent; simultaneous transitions SHALL complete in the same cycle if their raw changes are sampled in the same cycle.
REQ-018 EDGE_CNT SHALL increment by 1 in the cycle after each RISE[1]; 255 SHALL wrap to 0 with no flag.
REQ-019 All outputs SHALL be registered; no combinational path from SW to any output.

Reset
REQ-020 While Resetn = 0: synchronizer flops, counters, DB, RISE, FALL and EDGE_CNT SHALL be 0, asynchronously, independent of CLOCK_50.
REQ-021 Reset asserted mid-window SHALL discard the partial count; after release, evaluation SHALL restart from a counter of 0.
REQ-022 SW high at reset release SHALL produce a normal RISE after 2 + CNT_MAX edges (no suppressed edge).

Verification (CNT_MAX = 4)
REQ-023 Reset, SW = 00 for 10 cycles -> DB = 00, RISE = FALL = 00, EDGE_CNT = 0 throughout.
REQ-024 SW[0] 0->1 held -> DB[0] = 1 and RISE[0] = 1 at edge 6 after first sample, RISE[0] = 0 at edge 7; FALL, DB[1] unchanged.
REQ-025 SW[1] toggles 1,0,1 with 2-cycle dwell, then holds 1 -> no pulse during bounce; RISE[1] exactly once, 6 edges after the final stable sample; EDGE_CNT = 1 one cycle later.
REQ-026 256 clean SW[1] press/release cycles -> EDGE_CNT reaches 255, then 0; DB[1] and FALL[1] track each release.
REQ-027 SW[0] held 1, Resetn pulsed low at counter = 2 -> all outputs 0 immediately; RISE[0] at edge 6 after release.
REQ-028 SW 00->11 in the same cycle -> RISE = 11 in the same single cycle, DB = 11.
